keypad_scan_fifo: RTL and testbench
===================================

KEYPAD_SCAN_FIFO -- requirements
Module: keypad_scan_fifo

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clocks per row-drive period (min 2).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 4, consecutive matching samples required to accept a press or release (min 1).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port col  input  4  keypad columns, active-low, externally pulled up.
REQ-006 SHALL have port row  output  4  keypad rows; exactly one row low at a time.
REQ-007 SHALL have port pop  input  1  one-cycle strobe from MMIO read of the key-value register; removes the FIFO head.
REQ-008 SHALL have port clr  input  1  clears FIFO and overflow.
REQ-009 SHALL have port key_out  output  4  FIFO head key code; 0 when empty.
REQ-010 SHALL have port pressed  output  1  FIFO non-empty.
REQ-011 SHALL have port count  output  3  FIFO occupancy 0..4.
REQ-012 SHALL have port overflow  output  1  sticky flag: a key was dropped.

Function
REQ-013 SHALL drive row = ~(4'b0001 << ridx); ridx increments mod 4 once per SCAN_DIV clocks, in SCAN state only.
REQ-014 SHALL sample col once per row period, on the clock where the divider equals SCAN_DIV-1. The sample SHALL be registered through a 2-flop synchronizer before sampling.
REQ-015 Key code SHALL be ridx*4 + c, where c is the lowest-indexed low column. Multiple low columns SHALL resolve to the lowest index.
REQ-016 FSM SHALL have states SCAN, DEBOUNCE and HOLD.
REQ-017 SCAN: on a sample with any column low, SHALL latch the candidate code, freeze ridx and go to DEBOUNCE with match count 1. Otherwise ridx SHALL advance.
REQ-018 DEBOUNCE: each sample equal to the candidate SHALL increment the match count.
REQ-019 DEBOUNCE: when the count reaches DEBOUNCE_CNT, the candidate SHALL be pushed and the FSM SHALL go to HOLD.
REQ-020 DEBOUNCE: a differing sample, including all-high, SHALL return to SCAN with ridx advancing; nothing is pushed.
REQ-021 HOLD: ridx stays frozen. After DEBOUNCE_CNT consecutive all-high samples, SHALL go to SCAN and advance ridx. Any low sample SHALL restart the release count. No further pushes while in HOLD.
REQ-022 With DEBOUNCE_CNT=1, the detection sample itself SHALL push and enter HOLD.
REQ-023 FIFO SHALL be 4 entries, first-in first-out. Push and pop SHALL take effect one clock after the qualifying sample or strobe.
REQ-024 pop on empty SHALL be ignored.
REQ-025 Push when full SHALL drop the key and set overflow.
REQ-026 Push and pop in the same clock while full SHALL perform both; count SHALL be unchanged and no overflow SHALL be raised.
REQ-027 Push and pop in the same clock while empty SHALL perform only the push.
REQ-028 clr SHALL empty the FIFO and clear overflow next clock. It SHALL override push and pop in the same clock. FSM state SHALL be unaffected.
REQ-029 key_out, pressed and count SHALL be registered/derived from FIFO state only, with no combinational path from col.

Reset
REQ-030 On rst_n low, the block SHALL asynchronously set: state=SCAN, ridx=0, row=4'b1110, divider=0, match count=0, synchronizer=4'b1111.
REQ-031 On rst_n low, the FIFO SHALL be empty, with key_out=0, pressed=0, count=0, overflow=0.
REQ-032 Reset mid-debounce or mid-hold SHALL discard the candidate. After release, scanning SHALL resume from row 0 with no spurious push.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-033 Hold col=4'b1101 while row=4'b1011 (row 2, col 1) -> exactly one push of code 9. Expected: pressed=1, key_out=9, count=1; row frozen at 4'b1011 until 3 all-high samples after release.
REQ-034 Bounce: col low for 1 sample, high for 1, low for 1 -> no push; state returns to SCAN each time.
REQ-035 Press keys 1, 2, 3, 4, 5 sequentially without pop -> count=4 and overflow=1; pops return 1, 2, 3, 4; a pop at count=0 leaves count=0.
REQ-036 With count=4, push and pop coincide -> head 1 removed, new key appended, count=4, overflow stays 0.
REQ-037 clr asserted coincident with a push -> count=0 and overflow=0 next clock.
REQ-038 rst_n pulsed low mid-DEBOUNCE (async, between clock edges) -> row=4'b1110 and pressed=0 immediately; no key pushed after release.

Source files
------------

// File: rtl/keypad_scan_fifo.sv
// rtl/keypad_scan_fifo.sv - 4x4 keypad row scanner with debounce and a 4-entry key FIFO
module keypad_scan_fifo #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  input  logic       pop,
  input  logic       clr,
  output logic [3:0] key_out,
  output logic       pressed,
  output logic [2:0] count,
  output logic       overflow
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int MW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] CNT_LAST = MW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] div;
  logic [1:0]    ridx, ridx_nx;
  logic [MW-1:0] match, match_nx;
  logic [3:0]    cand, cand_nx;
  logic [3:0]    sync1, sync2;
  logic          tick, any_low, push;
  logic [1:0]    low_col;
  logic [3:0]    code;

  logic [3:0] mem [4];
  logic [1:0] rd_ptr, wr_ptr;
  logic [2:0] cnt;
  logic       ovf;
  logic       do_pop, do_push;

  assign tick    = (div == DIV_LAST);
  assign any_low = ~&sync2;
  assign code    = {ridx, low_col};
  assign row     = ~(4'b0001 << ridx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div   <= '0;
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      div   <= tick ? '0 : div + DW'(1);
      sync1 <= col;
      sync2 <= sync1;
    end
  end

  // Lowest-indexed low column wins when several are pressed.
  always_comb begin
    low_col = 2'd0;
    if (!sync2[0])      low_col = 2'd0;
    else if (!sync2[1]) low_col = 2'd1;
    else if (!sync2[2]) low_col = 2'd2;
    else if (!sync2[3]) low_col = 2'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SCAN;
      ridx  <= 2'd0;
      match <= '0;
      cand  <= 4'd0;
    end else begin
      state <= state_nx;
      ridx  <= ridx_nx;
      match <= match_nx;
      cand  <= cand_nx;
    end
  end

  // match counts accepted press samples in DEBOUNCE and all-high samples in HOLD.
  always_comb begin
    state_nx = state;
    ridx_nx  = ridx;
    match_nx = match;
    cand_nx  = cand;
    push     = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            cand_nx = code;
            if (DEBOUNCE_CNT == 1) begin
              push     = 1'b1;
              state_nx = HOLD;
              match_nx = '0;
            end else begin
              state_nx = DEBOUNCE;
              match_nx = MW'(1);
            end
          end else begin
            ridx_nx = ridx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (any_low && (code == cand)) begin
            if (match == CNT_LAST) begin
              push     = 1'b1;
              state_nx = HOLD;
              match_nx = '0;
            end else begin
              match_nx = match + MW'(1);
            end
          end else begin
            state_nx = SCAN;
            ridx_nx  = ridx + 2'd1;
            match_nx = '0;
          end
        end
        HOLD: begin
          if (any_low) begin
            match_nx = '0;
          end else if (match == CNT_LAST) begin
            state_nx = SCAN;
            ridx_nx  = ridx + 2'd1;
            match_nx = '0;
          end else begin
            match_nx = match + MW'(1);
          end
        end
        default: state_nx = SCAN;
      endcase
    end
  end

  // A full FIFO still accepts a push when a pop frees the head in the same clock.
  assign do_pop  = pop && (cnt != 3'd0);
  assign do_push = push && ((cnt != 3'd4) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      cnt    <= 3'd0;
      ovf    <= 1'b0;
    end else if (clr) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      cnt    <= 3'd0;
      ovf    <= 1'b0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (push && !do_push) ovf <= 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign key_out  = (cnt != 3'd0) ? mem[rd_ptr] : 4'd0;
  assign pressed  = (cnt != 3'd0);
  assign count    = cnt;
  assign overflow = ovf;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// tb/tb_keypad_scan_fifo.sv - bench for keypad_scan_fifo with SCAN_DIV=4, DEBOUNCE_CNT=3
module tb_keypad_scan_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] col;
  logic [3:0] row;
  logic       pop;
  logic       clr;
  logic [3:0] key_out;
  logic       pressed;
  logic [2:0] count;
  logic       overflow;

  logic [15:0] keys;
  logic        force_en;
  logic [3:0]  force_val;

  int n_checks = 0;
  int n_pass   = 0;

  int q[$];
  bit m_ovf;

  typedef struct {
    int op;
    int key;
    int exp_count;
    int exp_key;
    int exp_ovf;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  keypad_scan_fifo #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col      (col),
    .row      (row),
    .pop      (pop),
    .clr      (clr),
    .key_out  (key_out),
    .pressed  (pressed),
    .count    (count),
    .overflow (overflow)
  );

  // Physical keypad: a held key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
    if (force_en) col = force_val;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_count"}, int'(count), q.size());
    check({tag, "_key"}, int'(key_out), (q.size() != 0) ? q[0] : 0);
    check({tag, "_pressed"}, int'(pressed), int'(q.size() != 0));
    check({tag, "_ovf"}, int'(overflow), int'(m_ovf));
  endtask

  task automatic press(input int r, input logic [3:0] mask);
    keys = '0;
    for (int c = 0; c < 4; c++)
      if (mask[c]) keys[r*4+c] = 1'b1;
    step(60);
    keys = '0;
    step(40);
  endtask

  task automatic press_key(input int k);
    logic [3:0] m;
    m = 4'b0001 << (k % 4);
    press(k / 4, m);
  endtask

  task automatic do_pop();
    pop = 1'b1;
    step(1);
    pop = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  task automatic wait_row_enter(input logic [3:0] target);
    logic [3:0] prev;
    int n;
    bit ok;
    prev = row;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 64) begin
      @(negedge clk);
      n++;
      if (row == target && prev != target) ok = 1'b1;
      prev = row;
    end
    check("wait_row_enter", int'(ok), 1);
  endtask

  initial begin
    int n;
    int op, r, lo;
    logic [3:0] mask;

    tbl[0] = '{0, 1, 1, 1, 0};
    tbl[1] = '{0, 2, 2, 1, 0};
    tbl[2] = '{0, 3, 3, 1, 0};
    tbl[3] = '{0, 4, 4, 1, 0};
    tbl[4] = '{0, 5, 4, 1, 1};
    tbl[5] = '{1, 0, 3, 2, 1};
    tbl[6] = '{1, 0, 2, 3, 1};
    tbl[7] = '{1, 0, 1, 4, 1};
    tbl[8] = '{1, 0, 0, 0, 1};
    tbl[9] = '{1, 0, 0, 0, 1};

    rst_n = 1'b0;
    pop = 1'b0;
    clr = 1'b0;
    keys = '0;
    force_en = 1'b0;
    force_val = 4'hF;
    step(2);
    check("reset_row", int'(row), 'hE);
    check("reset_key", int'(key_out), 0);
    check("reset_pressed", int'(pressed), 0);
    check("reset_count", int'(count), 0);
    check("reset_ovf", int'(overflow), 0);
    rst_n = 1'b1;
    step(4);

    // Single press of key 9 (row 2, col 1) and the release hysteresis
    wait_row_enter(4'b1011);
    keys[9] = 1'b1;
    step(60);
    check("k9_count", int'(count), 1);
    check("k9_key", int'(key_out), 9);
    check("k9_pressed", int'(pressed), 1);
    check("k9_row_frozen", int'(row), 'hB);
    keys = '0;
    n = 0;
    while (row == 4'b1011 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("k9_release_latency", int'(n >= 11 && n <= 14), 1);
    check("k9_row_after", int'(row), 'h7);
    step(40);
    check("k9_single_push", int'(count), 1);
    do_pop();
    check("k9_pop_count", int'(count), 0);

    // Bounce: low, high, low, high on successive samples
    wait_row_enter(4'b1011);
    force_en = 1'b1;
    force_val = 4'b1101;
    step(4);
    check("bounce_s1_row", int'(row), 'hB);
    force_val = 4'hF;
    step(4);
    check("bounce_s2_row", int'(row), 'h7);
    force_val = 4'b1101;
    step(4);
    check("bounce_s3_row", int'(row), 'h7);
    force_val = 4'hF;
    step(4);
    check("bounce_s4_row", int'(row), 'hE);
    check("bounce_count", int'(count), 0);
    force_en = 1'b0;
    step(40);
    check("bounce_no_push", int'(count), 0);

    // Fill past capacity then drain, table-driven
    do_clr();
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].op == 0) press_key(tbl[i].key);
      else do_pop();
      check($sformatf("tbl%0d_count", i), int'(count), tbl[i].exp_count);
      check($sformatf("tbl%0d_key", i), int'(key_out), tbl[i].exp_key);
      check($sformatf("tbl%0d_ovf", i), int'(overflow), tbl[i].exp_ovf);
      check($sformatf("tbl%0d_pressed", i), int'(pressed), int'(tbl[i].exp_count != 0));
    end

    // Push of key 5 coinciding with a pop while full
    do_clr();
    for (int k = 1; k <= 4; k++) press_key(k);
    check("full_count", int'(count), 4);
    check("full_ovf", int'(overflow), 0);
    wait_row_enter(4'b1101);
    force_en = 1'b1;
    force_val = 4'b1101;
    step(11);
    check("pre_coincide_key", int'(key_out), 1);
    pop = 1'b1;
    step(1);
    pop = 1'b0;
    check("coincide_count", int'(count), 4);
    check("coincide_key", int'(key_out), 2);
    check("coincide_ovf", int'(overflow), 0);
    force_val = 4'hF;
    step(40);
    force_en = 1'b0;

    // clr coinciding with a push into a full FIFO
    wait_row_enter(4'b1101);
    force_en = 1'b1;
    force_val = 4'b1101;
    step(11);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_push_count", int'(count), 0);
    check("clr_push_ovf", int'(overflow), 0);
    check("clr_push_pressed", int'(pressed), 0);
    force_val = 4'hF;
    step(40);
    force_en = 1'b0;
    check("clr_push_after_count", int'(count), 0);
    check("clr_push_after_ovf", int'(overflow), 0);

    // Asynchronous reset in the middle of a debounce
    press_key(6);
    check("pre_reset_count", int'(count), 1);
    wait_row_enter(4'b1011);
    force_en = 1'b1;
    force_val = 4'b1101;
    step(5);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_row", int'(row), 'hE);
    check("async_reset_pressed", int'(pressed), 0);
    check("async_reset_count", int'(count), 0);
    force_val = 4'hF;
    force_en = 1'b0;
    step(2);
    rst_n = 1'b1;
    check("post_reset_row", int'(row), 'hE);
    step(80);
    check("post_reset_count", int'(count), 0);
    check("post_reset_ovf", int'(overflow), 0);

    // Randomized presses/pops/clears against a queue model
    do_clr();
    q.delete();
    m_ovf = 1'b0;
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 5);
      if (op <= 2) begin
        r = $urandom_range(0, 3);
        mask = 4'($urandom_range(1, 15));
        lo = -1;
        for (int c = 3; c >= 0; c--) if (mask[c]) lo = c;
        press(r, mask);
        if (q.size() < 4) q.push_back(r * 4 + lo);
        else m_ovf = 1'b1;
      end else if (op <= 4) begin
        do_pop();
        if (q.size() != 0) void'(q.pop_front());
      end else begin
        do_clr();
        q.delete();
        m_ovf = 1'b0;
      end
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
